// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART transmit path:
// FSM encoding, word-length codes, oversample factors and frame math.
package uart_pkg;

    localparam int ST_W = 5;

    localparam int S_IDLE  = 0;
    localparam int S_START = 1;
    localparam int S_DATA  = 2;
    localparam int S_PAR   = 3;
    localparam int S_STOP  = 4;

    localparam logic [ST_W-1:0] ST_IDLE  = 5'b00001;
    localparam logic [ST_W-1:0] ST_START = 5'b00010;
    localparam logic [ST_W-1:0] ST_DATA  = 5'b00100;
    localparam logic [ST_W-1:0] ST_PAR   = 5'b01000;
    localparam logic [ST_W-1:0] ST_STOP  = 5'b10000;

    localparam logic [1:0] WLS_5 = 2'd0;
    localparam logic [1:0] WLS_6 = 2'd1;
    localparam logic [1:0] WLS_7 = 2'd2;
    localparam logic [1:0] WLS_8 = 2'd3;

    localparam logic [4:0] OSM_16 = 5'd16;
    localparam logic [4:0] OSM_13 = 5'd13;

    // With the extra stop length selected, 5-bit words get 1.5 stop bits
    localparam logic [1:0] STOP15_WLS = WLS_5;

    function automatic logic [19:0] bit_period(
        input logic [15:0] dlr,
        input logic        osm
    );
        logic [19:0] div;
        logic [19:0] fac;
        div = (dlr == 16'd0) ? 20'd1 : {4'd0, dlr};
        fac = osm ? {15'd0, OSM_13} : {15'd0, OSM_16};
        return div * fac;
    endfunction

    function automatic logic [7:0] word_mask(input logic [1:0] wls);
        return 8'hFF >> (3'd3 - {1'b0, wls});
    endfunction

    function automatic logic parity_bit(
        input logic [7:0] data,
        input logic [1:0] wls,
        input logic       eps,
        input logic       sp
    );
        logic [7:0] d;
        d = data & word_mask(wls);
        if (sp) begin
            return ~eps;
        end
        return eps ? ^d : ~^d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Register-block side of the UART transmitter: THR writes,
// line/FIFO/divisor fields in, line output and status back.
interface uart_tx_if #(
    parameter int FIFO_AW = 4
);

    logic [7:0]       thr_wdata_in;
    logic             thr_wr_in;
    logic             fifoen_in;
    logic             txclr_in;
    logic             utrst_in;
    logic [1:0]       wls_in;
    logic             stb_in;
    logic             pen_in;
    logic             eps_in;
    logic             sp_in;
    logic             bc_in;
    logic [15:0]      dlr_in;
    logic             osm_in;
    logic             txd_out;
    logic             thre_out;
    logic             temt_out;
    logic [FIFO_AW:0] tx_level_out;
    logic             wr_drop_out;

    modport master (
        output thr_wdata_in,
        output thr_wr_in,
        output fifoen_in,
        output txclr_in,
        output utrst_in,
        output wls_in,
        output stb_in,
        output pen_in,
        output eps_in,
        output sp_in,
        output bc_in,
        output dlr_in,
        output osm_in,
        input  txd_out,
        input  thre_out,
        input  temt_out,
        input  tx_level_out,
        input  wr_drop_out
    );

    modport slave (
        input  thr_wdata_in,
        input  thr_wr_in,
        input  fifoen_in,
        input  txclr_in,
        input  utrst_in,
        input  wls_in,
        input  stb_in,
        input  pen_in,
        input  eps_in,
        input  sp_in,
        input  bc_in,
        input  dlr_in,
        input  osm_in,
        output txd_out,
        output thre_out,
        output temt_out,
        output tx_level_out,
        output wr_drop_out
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO with selectable capacity (DEPTH or a single
// holding register), synchronous clear and occupancy count.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic         fifoen,
    input  logic [7:0]   wdata,
    output logic [7:0]   rdata,
    output logic [AW:0]  level,
    output logic         full,
    output logic         empty
);

    localparam logic [AW:0] CAP_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CAP_ONE  = (AW+1)'(1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cap;
    logic          do_push;
    logic          do_pop;

    assign cap   = fifoen ? CAP_FULL : CAP_ONE;
    assign empty = (level == '0);
    assign full  = (level >= cap);

    // A pop frees a slot in the same cycle, so push still lands when full
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && !clear && (!full || do_pop);

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: TX FIFO, bit-period timing from DLR/OSM and the
// frame serialiser driving txd_out, with THRE/TEMT status.
module uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic     apb_clk_in,
    input  logic     apb_rst_in,
    uart_tx_if.slave bus
);

    logic [ST_W-1:0]  state;
    logic [20:0]      cnt;
    logic [20:0]      limit;
    logic             cnt_end;
    logic [19:0]      p_q;
    logic [19:0]      p_new;
    logic [20:0]      stop_q;
    logic [20:0]      stop_new;
    logic [7:0]       sh;
    logic [2:0]       bit_idx;
    logic [2:0]       last_idx;
    logic             pen_q;
    logic             par_q;
    logic             fifoen_q;

    logic             clear;
    logic             push;
    logic             pop;
    logic             can_pop;
    logic             drop;
    logic             line;

    logic [7:0]       fifo_rdata;
    logic [FIFO_AW:0] fifo_level;
    logic             fifo_full;
    logic             fifo_empty;

    logic             txd_q;
    logic             thre_q;
    logic             temt_q;
    logic             drop_q;

    assign clear   = bus.txclr_in
                  || (bus.fifoen_in != fifoen_q)
                  || !bus.utrst_in;
    assign push    = bus.thr_wr_in && bus.utrst_in;
    assign can_pop = !fifo_empty && !clear;

    assign limit   = state[S_STOP] ? stop_q : {1'b0, p_q};
    assign cnt_end = (cnt == limit - 21'd1);

    assign pop  = can_pop
               && (state[S_IDLE] || (state[S_STOP] && cnt_end));
    assign drop = push && !clear && fifo_full && !pop;

    assign p_new = bit_period(bus.dlr_in, bus.osm_in);

    always_comb begin
        stop_new = {1'b0, p_new};
        if (bus.stb_in) begin
            if (bus.wls_in == STOP15_WLS) begin
                stop_new = {1'b0, p_new} + {2'b0, p_new[19:1]};
            end else begin
                stop_new = {p_new, 1'b0};
            end
        end
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk    (apb_clk_in),
        .rst    (apb_rst_in),
        .push   (push),
        .pop    (pop),
        .clear  (clear),
        .fifoen (bus.fifoen_in),
        .wdata  (bus.thr_wdata_in),
        .rdata  (fifo_rdata),
        .level  (fifo_level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
        if (apb_rst_in) begin
            fifoen_q <= 1'b0;
        end else begin
            fifoen_q <= bus.fifoen_in;
        end
    end

    always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
        if (apb_rst_in) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else if (!bus.utrst_in) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            unique case (1'b1)
                state[S_IDLE]: begin
                    cnt <= '0;
                    if (pop) begin
                        state <= ST_START;
                    end
                end
                state[S_START]: begin
                    if (cnt_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end else begin
                        cnt <= cnt + 21'd1;
                    end
                end
                state[S_DATA]: begin
                    if (cnt_end) begin
                        cnt <= '0;
                        if (bit_idx == last_idx) begin
                            state <= pen_q ? ST_PAR : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 21'd1;
                    end
                end
                state[S_PAR]: begin
                    if (cnt_end) begin
                        cnt   <= '0;
                        state <= ST_STOP;
                    end else begin
                        cnt <= cnt + 21'd1;
                    end
                end
                state[S_STOP]: begin
                    if (cnt_end) begin
                        cnt   <= '0;
                        state <= pop ? ST_START : ST_IDLE;
                    end else begin
                        cnt <= cnt + 21'd1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Frame fields are latched with the byte so mid-frame writes to
    // the line control fields cannot corrupt the frame in flight
    always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
        if (apb_rst_in) begin
            sh       <= '0;
            p_q      <= 20'd16;
            stop_q   <= 21'd16;
            last_idx <= 3'd7;
            pen_q    <= 1'b0;
            par_q    <= 1'b0;
        end else if (pop) begin
            sh       <= fifo_rdata;
            p_q      <= p_new;
            stop_q   <= stop_new;
            last_idx <= {1'b0, bus.wls_in} + 3'd4;
            pen_q    <= bus.pen_in;
            par_q    <= parity_bit(fifo_rdata, bus.wls_in,
                                   bus.eps_in, bus.sp_in);
        end else if (state[S_DATA] && cnt_end) begin
            sh <= {1'b0, sh[7:1]};
        end
    end

    always_comb begin
        line = 1'b1;
        unique case (1'b1)
            state[S_START]: line = 1'b0;
            state[S_DATA]:  line = sh[0];
            state[S_PAR]:   line = par_q;
            default:        line = 1'b1;
        endcase
    end

    always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
        if (apb_rst_in) begin
            txd_q  <= 1'b1;
            thre_q <= 1'b1;
            temt_q <= 1'b1;
            drop_q <= 1'b0;
        end else if (!bus.utrst_in) begin
            txd_q  <= 1'b1;
            thre_q <= 1'b1;
            temt_q <= 1'b1;
            drop_q <= 1'b0;
        end else begin
            txd_q  <= bus.bc_in ? 1'b0 : line;
            thre_q <= fifo_empty;
            temt_q <= fifo_empty && state[S_IDLE];
            drop_q <= drop;
        end
    end

    assign bus.txd_out      = txd_q;
    assign bus.thre_out     = thre_q;
    assign bus.temt_out     = temt_q;
    assign bus.wr_drop_out  = drop_q;
    assign bus.tx_level_out = fifo_level;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx: expected txd waveform built per
// clock from frame rules and compared sample by sample.
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_if #(.FIFO_AW(4)) bus ();

    uart_tx #(
        .FIFO_DEPTH (16),
        .FIFO_AW    (4)
    ) dut (
        .apb_clk_in (clk),
        .apb_rst_in (rst),
        .bus        (bus)
    );

    int total = 0;
    int bad   = 0;

    bit         exp_q[$];
    logic [7:0] bytes_a [0:31];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic void push_bits(input bit v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endfunction

    function automatic void push_frame(input logic [7:0] d);
        int p, nb, ones;
        bit par;
        p  = (bus.dlr_in == 16'd0 ? 1 : int'(bus.dlr_in))
           * (bus.osm_in ? 13 : 16);
        nb = int'(bus.wls_in) + 5;
        push_bits(1'b0, p);
        ones = 0;
        for (int i = 0; i < nb; i++) begin
            push_bits(d[i], p);
            ones += int'(d[i]);
        end
        if (bus.pen_in) begin
            if (bus.sp_in) par = !bus.eps_in;
            else if (bus.eps_in) par = (ones % 2) == 1;
            else par = (ones % 2) == 0;
            push_bits(par, p);
        end
        if (!bus.stb_in) push_bits(1'b1, p);
        else if (bus.wls_in == 2'd0) push_bits(1'b1, p + p / 2);
        else push_bits(1'b1, 2 * p);
    endfunction

    task automatic set_cfg(input int dlr, input bit osm, input int wls,
                           input bit pen, input bit eps, input bit sp,
                           input bit stb, input bit fifoen);
        bus.dlr_in    = 16'(dlr);
        bus.osm_in    = osm;
        bus.wls_in    = 2'(wls);
        bus.pen_in    = pen;
        bus.eps_in    = eps;
        bus.sp_in     = sp;
        bus.stb_in    = stb;
        bus.fifoen_in = fifoen;
        repeat (3) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] b);
        bus.thr_wdata_in = b;
        bus.thr_wr_in    = 1'b1;
        @(negedge clk);
        bus.thr_wr_in    = 1'b0;
    endtask

    // bytes_a[0] starts a frame; the rest are written 3 cycles later
    task automatic run_wave(input string tag, input int nb,
                            input int clr_at, input int brk_rel);
        int cap, acc, n, mism, drops, lmax, temt_mid;
        cap = bus.fifoen_in ? 16 : 1;
        acc = (nb - 1 > cap) ? cap : nb - 1;
        exp_q.delete();
        push_frame(bytes_a[0]);
        if (clr_at < 0) begin
            for (int i = 1; i <= acc; i++) push_frame(bytes_a[i]);
        end
        push_bits(1'b1, 40);
        for (int i = 0; i <= brk_rel; i++) exp_q[i] = 1'b0;
        n = exp_q.size();
        mism = 0;
        drops = 0;
        lmax = 0;
        temt_mid = 1;
        wr(bytes_a[0]);
        fork
            begin
                repeat (3) @(negedge clk);
                for (int i = 1; i < nb; i++) wr(bytes_a[i]);
            end
            begin
                for (int i = 0; i < n + 2; i++) begin
                    @(negedge clk);
                    if (bus.wr_drop_out === 1'b1) drops++;
                    if (int'(bus.tx_level_out) > lmax)
                        lmax = int'(bus.tx_level_out);
                    if (i == 10) temt_mid = int'(bus.temt_out);
                end
            end
            begin
                @(negedge clk);
                for (int i = 0; i < n; i++) begin
                    @(negedge clk);
                    if (bus.txd_out !== exp_q[i]) mism++;
                    bus.txclr_in = (i == clr_at);
                    if (i == brk_rel) bus.bc_in = 1'b0;
                end
                bus.txclr_in = 1'b0;
            end
        join
        chk({tag, ".wave"}, 32'(mism), 32'd0);
        chk({tag, ".drop"}, 32'(drops), 32'(nb - 1 - acc));
        chk({tag, ".lvl"}, 32'(lmax), 32'(acc));
        chk({tag, ".temt_busy"}, 32'(temt_mid), 32'd0);
        chk({tag, ".thre"}, 32'(bus.thre_out), 32'd1);
        chk({tag, ".temt"}, 32'(bus.temt_out), 32'd1);
    endtask

    initial begin
        bus.thr_wdata_in = '0;
        bus.thr_wr_in    = 1'b0;
        bus.fifoen_in    = 1'b1;
        bus.txclr_in     = 1'b0;
        bus.utrst_in     = 1'b1;
        bus.wls_in       = 2'd3;
        bus.stb_in       = 1'b0;
        bus.pen_in       = 1'b0;
        bus.eps_in       = 1'b0;
        bus.sp_in        = 1'b0;
        bus.bc_in        = 1'b0;
        bus.dlr_in       = 16'd1;
        bus.osm_in       = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst.txd", 32'(bus.txd_out), 32'd1);
        chk("rst.thre", 32'(bus.thre_out), 32'd1);
        chk("rst.temt", 32'(bus.temt_out), 32'd1);
        chk("rst.lvl", 32'(bus.tx_level_out), 32'd0);
        chk("rst.drop", 32'(bus.wr_drop_out), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle.txd", 32'(bus.txd_out), 32'd1);
        chk("idle.temt", 32'(bus.temt_out), 32'd1);

        set_cfg(1, 0, 3, 0, 0, 0, 0, 1);
        bytes_a[0] = 8'h55;
        run_wave("8n1", 1, -1, -1);

        set_cfg(2, 1, 2, 1, 1, 0, 1, 1);
        bytes_a[0] = 8'h03;
        run_wave("7e2", 1, -1, -1);

        set_cfg(1, 0, 0, 1, 0, 1, 1, 1);
        bytes_a[0] = 8'($urandom);
        run_wave("5s15", 1, -1, -1);

        for (int it = 0; it < 8; it++) begin
            int nb;
            set_cfg(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            nb = int'($urandom_range(1, 3));
            for (int i = 0; i < nb; i++) bytes_a[i] = 8'($urandom);
            run_wave($sformatf("rnd%0d", it), nb, -1, -1);
        end

        set_cfg(1, 0, 3, 0, 0, 0, 0, 1);
        for (int i = 0; i < 18; i++) bytes_a[i] = 8'($urandom);
        run_wave("full", 18, -1, -1);

        for (int i = 0; i < 6; i++) bytes_a[i] = 8'($urandom);
        run_wave("clr", 6, 50, -1);

        bus.bc_in = 1'b1;
        @(negedge clk);
        bytes_a[0] = 8'hFF;
        run_wave("brk", 1, -1, 80);

        wr(8'h00);
        wr(8'h00);
        wr(8'h00);
        repeat (40) @(negedge clk);
        chk("abort.pre_txd", 32'(bus.txd_out), 32'd0);
        chk("abort.pre_lvl", 32'(bus.tx_level_out), 32'd2);
        bus.utrst_in = 1'b0;
        @(negedge clk);
        chk("abort.txd", 32'(bus.txd_out), 32'd1);
        chk("abort.lvl", 32'(bus.tx_level_out), 32'd0);
        wr(8'h12);
        @(negedge clk);
        chk("abort.wr_lvl", 32'(bus.tx_level_out), 32'd0);
        chk("abort.thre", 32'(bus.thre_out), 32'd1);
        chk("abort.temt", 32'(bus.temt_out), 32'd1);
        chk("abort.drop", 32'(bus.wr_drop_out), 32'd0);
        bus.utrst_in = 1'b1;
        repeat (2) @(negedge clk);
        bytes_a[0] = 8'hA5;
        run_wave("recover", 1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
